// File: rtl/ps2_scancode_receiver_if.sv
// Signal bundle between the PS/2 debouncer, the scan-code receiver and its consumer.
// The master side drives the filtered PS/2 pair; the slave side is the receiver.
interface ps2_scancode_receiver_if;
    logic       k_clk_f;
    logic       k_data_f;
    logic [7:0] code;
    logic       extended;
    logic       released;
    logic       code_valid;
    logic       frame_error;

    modport master (
        output k_clk_f, k_data_f,
        input  code, extended, released, code_valid, frame_error
    );

    modport slave (
        input  k_clk_f, k_data_f,
        output code, extended, released, code_valid, frame_error
    );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// PS/2 frame deserialiser.
// It folds the E0/F0 prefixes into flags and emits one key event per make or break code.
//
// state  | meaning
// IDLE   | bus idle, waiting for a start-bit fall
// DATA   | shifting in 8 data bits, LSB first
// PARITY | waiting for the odd-parity bit
// STOP   | waiting for the stop bit, then judging the frame
module ps2_scancode_receiver #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ps2_scancode_receiver_if.slave bus
);
    localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      state, state_nx;
    logic        c1, c2, d1, d2;
    logic [2:0]  bit_cnt, bit_cnt_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        par_bit, par_bit_nx;
    logic [16:0] tmo_cnt, tmo_cnt_nx;
    logic        ext_pend, brk_pend;
    logic        fall, frame_good, frame_bad;

    assign fall = c2 & ~c1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            c1              <= 1'b1;
            c2              <= 1'b1;
            d1              <= 1'b1;
            d2              <= 1'b1;
            bit_cnt         <= '0;
            shreg           <= '0;
            par_bit         <= 1'b0;
            tmo_cnt         <= '0;
            ext_pend        <= 1'b0;
            brk_pend        <= 1'b0;
            bus.code        <= '0;
            bus.extended    <= 1'b0;
            bus.released    <= 1'b0;
            bus.code_valid  <= 1'b0;
            bus.frame_error <= 1'b0;
        end else begin
            c1              <= bus.k_clk_f;
            c2              <= c1;
            d1              <= bus.k_data_f;
            d2              <= d1;
            state           <= state_nx;
            bit_cnt         <= bit_cnt_nx;
            shreg           <= shreg_nx;
            par_bit         <= par_bit_nx;
            tmo_cnt         <= tmo_cnt_nx;
            bus.code_valid  <= 1'b0;
            bus.frame_error <= 1'b0;
            if (frame_good) begin
                if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    bus.code       <= shreg;
                    bus.extended   <= ext_pend;
                    bus.released   <= brk_pend;
                    bus.code_valid <= 1'b1;
                    ext_pend       <= 1'b0;
                    brk_pend       <= 1'b0;
                end
            end else if (frame_bad) begin
                bus.frame_error <= 1'b1;
                ext_pend        <= 1'b0;
                brk_pend        <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        par_bit_nx = par_bit;
        tmo_cnt_nx = tmo_cnt;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                tmo_cnt_nx = '0;
                if (fall && !d1) begin
                    state_nx   = DATA;
                    bit_cnt_nx = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_nx   = {d1, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_bit_nx = d1;
                    state_nx   = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_nx = IDLE;
                    if ((^{shreg, par_bit}) && d1) frame_good = 1'b1;
                    else                          frame_bad  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Inter-edge watchdog; a fall arriving on the terminal cycle takes precedence.
        if (state != IDLE) begin
            if (fall) begin
                tmo_cnt_nx = '0;
            end else if (tmo_cnt == TMO_LAST) begin
                tmo_cnt_nx = '0;
                state_nx   = IDLE;
                frame_bad  = 1'b1;
            end else begin
                tmo_cnt_nx = tmo_cnt + 17'd1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for the PS/2 scan-code receiver.
// Counts output pulses on the falling clock edge and checks them against hand-computed values.
module tb_ps2_scancode_receiver;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   n_err = 0;
    int   last_valid_cyc = -1;
    int   last_err_cyc = -1;
    int   last_fall_cyc = 0;

    ps2_scancode_receiver_if bus ();

    ps2_scancode_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.code_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (bus.frame_error === 1'b1) begin
            n_err++;
            last_err_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.k_data_f = b;
        tick(4);
        bus.k_clk_f   = 1'b0;
        last_fall_cyc = cyc;
        tick(8);
        bus.k_clk_f = 1'b1;
        tick(4);
    endtask

    // nbits < 11 sends only the leading part of a frame (start bit included)
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop, input int nbits);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        bus.k_data_f = 1'b1;
        tick(10);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11);
    endtask

    initial begin
        bus.k_clk_f  = 1'b1;
        bus.k_data_f = 1'b1;
        tick(3);
        check("rst_code", 32'(bus.code), 32'h00);
        check("rst_ext", 32'(bus.extended), 0);
        check("rst_rel", 32'(bus.released), 0);
        check("rst_cv", 32'(bus.code_valid), 0);
        check("rst_fe", 32'(bus.frame_error), 0);
        rst_n = 1'b1;
        tick(5);

        good(8'h1C);
        check("make_cnt", n_valid, 1);
        check("make_lat", last_valid_cyc, last_fall_cyc + 2);
        check("make_code", 32'(bus.code), 32'h1C);
        check("make_ext", 32'(bus.extended), 0);
        check("make_rel", 32'(bus.released), 0);
        check("make_err", n_err, 0);

        good(8'hF0);
        check("brk_prefix_silent", n_valid, 1);
        good(8'h1C);
        check("brk_cnt", n_valid, 2);
        check("brk_code", 32'(bus.code), 32'h1C);
        check("brk_rel", 32'(bus.released), 1);
        check("brk_ext", 32'(bus.extended), 0);

        good(8'hE0);
        good(8'hF0);
        check("extbrk_prefix_silent", n_valid, 2);
        good(8'h75);
        check("extbrk_cnt", n_valid, 3);
        check("extbrk_code", 32'(bus.code), 32'h75);
        check("extbrk_ext", 32'(bus.extended), 1);
        check("extbrk_rel", 32'(bus.released), 1);
        good(8'h1C);
        check("after_cnt", n_valid, 4);
        check("after_ext", 32'(bus.extended), 0);
        check("after_rel", 32'(bus.released), 0);

        good(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        check("par_err_cnt", n_err, 1);
        check("par_no_valid", n_valid, 4);
        check("par_err_lat", last_err_cyc, last_fall_cyc + 2);
        good(8'h1C);
        check("par_next_cnt", n_valid, 5);
        check("par_next_rel", 32'(bus.released), 0);

        send_frame(8'h1C, 1'b0, 1'b0, 11);
        check("stop_err_cnt", n_err, 2);
        check("stop_no_valid", n_valid, 5);

        send_frame(8'h29, 1'b0, 1'b1, 5);
        tick(TMO + 20);
        check("tmo_err_cnt", n_err, 3);
        check("tmo_err_lat", last_err_cyc, last_fall_cyc + 2 + TMO);
        check("tmo_no_valid", n_valid, 5);
        good(8'h29);
        check("tmo_next_cnt", n_valid, 6);
        check("tmo_next_code", 32'(bus.code), 32'h29);

        good(8'hE0);
        send_frame(8'h1C, 1'b0, 1'b1, 5);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrst_code", 32'(bus.code), 32'h00);
        check("midrst_ext", 32'(bus.extended), 0);
        check("midrst_rel", 32'(bus.released), 0);
        tick(TMO + 20);
        check("midrst_no_valid", n_valid, 6);
        check("midrst_no_err", n_err, 3);
        good(8'h1C);
        check("midrst_next_cnt", n_valid, 7);
        check("midrst_next_code", 32'(bus.code), 32'h1C);
        check("midrst_next_ext", 32'(bus.extended), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_receiver.md
# ps2_scancode_receiver

Deserialises the debounced PS/2 clock/data pair into 11-bit frames: start bit, 8 data bits LSB first, odd parity, stop bit. Folds the 0xE0 (extended) and 0xF0 (break) prefixes into flags and emits one decoded key event per make or break code. Sits directly downstream of the keyboard debouncer, taking its filtered outputs. Feeds the note-mapping and tone logic.

## Interface
- TIMEOUT_CYCLES, 100000: system clocks (2 ms at 50 MHz) allowed between falling edges inside a frame before abort; counter width 17 bits.
- clk  in  1  50 MHz system clock; every register is on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- k_clk_f  in  1  debounced PS/2 clock.
- k_data_f  in  1  debounced PS/2 data.
- code  out  8  last decoded scan code; holds until the next event.
- extended  out  1  event was prefixed by 0xE0; holds with code.
- released  out  1  event was prefixed by 0xF0 (break); holds with code.
- code_valid  out  1  one-cycle pulse per decoded event.
- frame_error  out  1  one-cycle pulse on parity, stop or timeout failure.

## Operation
- Input stage: k_clk_f and k_data_f are registered twice (c1/c2 and d1/d2). fall = c2 & ~c1. Bits are sampled from d1 on fall.
- Frame FSM states:
  - IDLE: on fall, if d1 = 0 go to DATA with bit counter = 0. If d1 = 1, treat as a glitch: stay in IDLE, no error.
  - DATA: on each fall, shift d1 into shreg[7] with a right shift (LSB arrives first). After the 8th bit go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, the frame is good if ^{shreg, parity} = 1 and d1 = 1. Either way, return to IDLE.
- Good frame, byte 0xE0: set ext_pend. No output.
- Good frame, byte 0xF0: set brk_pend. No output.
- Good frame, any other byte:
  - code ← byte, extended ← ext_pend, released ← brk_pend.
  - Pulse code_valid.
  - Clear both pending flags.
- Bad frame (parity or stop failure): pulse frame_error, clear both pending flags, leave code/extended/released unchanged.
- Timeout: in DATA, PARITY or STOP, the counter increments every clk and clears on each fall. When it reaches TIMEOUT_CYCLES−1:
  - Return to IDLE.
  - Pulse frame_error.
  - Clear the pending flags.
  - The counter is held at 0 while in IDLE.
- Simultaneous events: a fall in the same cycle the timeout hits means the fall wins, and the counter clears.
- Reset values (rst_n low at a clk edge):
  - FSM = IDLE, all counters and shreg = 0.
  - c1, c2 and d1, d2 = 1 (bus idle-high).
  - code = 0x00, extended = released = code_valid = frame_error = 0.
  - ext_pend = brk_pend = 0.
  - Reset mid-frame discards the partial frame with no pulse.

## Timing
- Edge detection: k_clk_f first sampled low into c1 at edge N, so fall is true during cycle N→N+1. The FSM acts at edge N+1.
- Latency: code_valid / frame_error go high after edge N+1 of the stop-bit fall, for exactly one cycle. code/extended/released update on that same edge.
- Outputs are fully registered; there is no combinational path from inputs.
- No backpressure: the consumer must sample on code_valid. Frames are at least ~60 µs apart, so events can never be closer than that.

## Test plan
- Make code: frame 0x1C with parity 0, stop 1 → exactly one code_valid, code = 0x1C, extended = 0, released = 0, at N+1 after the stop fall.
- Break sequence: frames F0 then 1C → no pulse after F0; one pulse after 1C with code = 0x1C, released = 1, extended = 0.
- Extended break: frames E0, F0, 75 → a single pulse with code = 0x75, extended = 1, released = 1. A following make of 0x1C has both flags at 0.
- Parity error: F0, then 0x1C with parity = 1, then 0x1C good → frame_error after the second frame and no code_valid for it; the final event has released = 0.
- Timeout: 5 bits, then k_clk_f held high for TIMEOUT_CYCLES clocks → frame_error pulse, FSM back in IDLE. The next good 0x29 frame decodes to code = 0x29.
- Reset mid-frame: rst_n low for one cycle after the 4th data bit → all outputs 0, no pulses. The next full 0x1C frame decodes normally.
